// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus bundle: CPU port, VGA prefetch port and VRAM port.
// master = arbiter side, slave = requesters plus the RAM itself.
interface vram_arbiter_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32
);
   logic                    cpu_rd_en;
   logic                    cpu_wr_en;
   logic [ADDR_WIDTH-1:0]   cpu_addr;
   logic [DATA_WIDTH-1:0]   cpu_wr_data;
   logic [DATA_WIDTH/8-1:0] cpu_wr_strobe;
   logic [DATA_WIDTH-1:0]   cpu_rd_data;
   logic                    cpu_ack;
   logic                    vga_req;
   logic [ADDR_WIDTH-1:0]   vga_addr;
   logic                    vga_gnt;
   logic                    vga_rd_valid;
   logic [DATA_WIDTH-1:0]   vga_rd_data;
   logic                    mem_en;
   logic [DATA_WIDTH/8-1:0] mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wr_data;
   logic [DATA_WIDTH-1:0]   mem_rd_data;

   modport master (
      input  cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wr_data, cpu_wr_strobe,
      output cpu_rd_data, cpu_ack,
      input  vga_req, vga_addr,
      output vga_gnt, vga_rd_valid, vga_rd_data,
      output mem_en, mem_we, mem_addr, mem_wr_data,
      input  mem_rd_data
   );

   modport slave (
      output cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wr_data, cpu_wr_strobe,
      input  cpu_rd_data, cpu_ack,
      output vga_req, vga_addr,
      input  vga_gnt, vga_rd_valid, vga_rd_data,
      input  mem_en, mem_we, mem_addr, mem_wr_data,
      output mem_rd_data
   );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: VGA-priority sharing of one sync-read VRAM with the CPU,
// with a bounded wait so a streaming VGA cannot starve the CPU.
module vram_arbiter #(
   parameter int ADDR_WIDTH   = 15,
   parameter int DATA_WIDTH   = 32,
   parameter int CPU_MAX_WAIT = 4
) (
   input logic           clk,
   input logic           rst,
   vram_arbiter_if.master bus
);
   localparam int WW = (CPU_MAX_WAIT > 0) ? $clog2(CPU_MAX_WAIT + 1) : 1;
   localparam logic [WW-1:0] WMAX = WW'(CPU_MAX_WAIT);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_VGA  = 2'd2
   } owner_t;

   owner_t         owner_q;
   owner_t         owner_d;
   logic           cpu_pend;
   logic [WW-1:0]  wait_cnt;
   logic [WW-1:0]  wait_d;
   logic           cpu_elig;
   logic           cpu_win;
   logic           vga_win;

   // Grant selection, wait-counter update and VRAM port muxing.
   always_comb begin
      cpu_elig = (bus.cpu_rd_en | bus.cpu_wr_en) & ~cpu_pend;
      cpu_win  = ~rst & cpu_elig & ((wait_cnt == WMAX) | ~bus.vga_req);
      vga_win  = ~rst & ~cpu_win & bus.vga_req;

      owner_d = OWN_NONE;
      unique case (1'b1)
         cpu_win: owner_d = OWN_CPU;
         vga_win: owner_d = OWN_VGA;
         default: owner_d = OWN_NONE;
      endcase

      wait_d = wait_cnt;
      if (cpu_win || !cpu_elig)
         wait_d = '0;
      else if (wait_cnt != WMAX)
         wait_d = wait_cnt + 1'b1;

      bus.mem_en      = cpu_win | vga_win;
      bus.mem_we      = (cpu_win & bus.cpu_wr_en) ? bus.cpu_wr_strobe : '0;
      bus.mem_addr    = cpu_win ? bus.cpu_addr : bus.vga_addr;
      bus.mem_wr_data = bus.cpu_wr_data;
      bus.vga_gnt     = vga_win;
   end

   // Response side: the previous cycle's owner qualifies the RAM data.
   always_comb begin
      bus.cpu_ack      = (owner_q == OWN_CPU);
      bus.vga_rd_valid = (owner_q == OWN_VGA);
      bus.cpu_rd_data  = bus.mem_rd_data;
      bus.vga_rd_data  = bus.mem_rd_data;
   end

   // Owner, pending-ack and starvation-counter state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q  <= OWN_NONE;
         cpu_pend <= 1'b0;
         wait_cnt <= '0;
      end else begin
         owner_q  <= owner_d;
         cpu_pend <= cpu_win;
         wait_cnt <= wait_d;
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: cycle vectors plus a read-data
// scoreboard backed by a shadow copy of the VRAM contents.
module tb_vram_arbiter;
   localparam int AW = 15;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic clk = 1'b0;
   logic rst;
   logic load;

   always #5 clk = ~clk;

   vram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   vram_arbiter #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .CPU_MAX_WAIT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [DW-1:0] vram   [0:1023];
   logic [DW-1:0] shadow [0:1023];

   // Synchronous-read single-port VRAM with byte enables.
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 1024; i++) vram[i] <= shadow[i];
      end else if (bus.mem_en) begin
         for (int b = 0; b < SW; b++)
            if (bus.mem_we[b])
               vram[bus.mem_addr[9:0]][8*b +: 8] <= bus.mem_wr_data[8*b +: 8];
         bus.mem_rd_data <= vram[bus.mem_addr[9:0]];
      end
   end

   typedef struct {
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [SW-1:0] st;
      logic          vreq;
      logic [AW-1:0] vaddr;
      logic          en;
      logic [SW-1:0] we;
      logic          gnt;
      logic          ack;
      logic          vld;
   } vec_t;

   typedef struct {
      logic          chk;
      logic [DW-1:0] d;
   } exp_t;

   vec_t          vecs  [$];
   exp_t          cpu_q [$];
   logic [DW-1:0] vga_q [$];
   int            checks = 0;
   int            errors = 0;

   function automatic vec_t mk(logic rd, logic wr, logic [AW-1:0] a,
                               logic [DW-1:0] wd, logic [SW-1:0] st,
                               logic vreq, logic [AW-1:0] va, logic en,
                               logic [SW-1:0] we, logic gnt, logic ack,
                               logic vld);
      vec_t r;
      r.rd = rd; r.wr = wr; r.addr = a; r.wd = wd; r.st = st;
      r.vreq = vreq; r.vaddr = va; r.en = en; r.we = we;
      r.gnt = gnt; r.ack = ack; r.vld = vld;
      return r;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.cpu_rd_en     = v.rd;
      bus.cpu_wr_en     = v.wr;
      bus.cpu_addr      = v.addr;
      bus.cpu_wr_data   = v.wd;
      bus.cpu_wr_strobe = v.st;
      bus.vga_req       = v.vreq;
      bus.vga_addr      = v.vaddr;
   endtask

   task automatic apply(input vec_t v, input int idx);
      exp_t e;
      @(negedge clk);
      drive(v);
      #1;
      chk($sformatf("v%0d mem_en", idx), DW'(bus.mem_en), DW'(v.en));
      chk($sformatf("v%0d mem_we", idx), DW'(bus.mem_we), DW'(v.we));
      chk($sformatf("v%0d vga_gnt", idx), DW'(bus.vga_gnt), DW'(v.gnt));
      chk($sformatf("v%0d cpu_ack", idx), DW'(bus.cpu_ack), DW'(v.ack));
      chk($sformatf("v%0d vga_vld", idx), DW'(bus.vga_rd_valid), DW'(v.vld));
      if (v.en)
         chk($sformatf("v%0d mem_addr", idx), DW'(bus.mem_addr),
             DW'(v.gnt ? v.vaddr : v.addr));
      if (bus.cpu_ack) begin
         if (cpu_q.size() == 0) begin
            chk($sformatf("v%0d cpu_q_underflow", idx), 32'd1, 32'd0);
         end else begin
            e = cpu_q.pop_front();
            if (e.chk)
               chk($sformatf("v%0d cpu_rd_data", idx), bus.cpu_rd_data, e.d);
         end
      end
      if (bus.vga_rd_valid) begin
         if (vga_q.size() == 0)
            chk($sformatf("v%0d vga_q_underflow", idx), 32'd1, 32'd0);
         else
            chk($sformatf("v%0d vga_rd_data", idx), bus.vga_rd_data,
                vga_q.pop_front());
      end
      if (v.en && v.gnt) begin
         vga_q.push_back(shadow[v.vaddr[9:0]]);
      end else if (v.en && v.we == '0) begin
         e.chk = 1'b1;
         e.d   = shadow[v.addr[9:0]];
         cpu_q.push_back(e);
      end else if (v.en) begin
         e.chk = 1'b0;
         e.d   = '0;
         cpu_q.push_back(e);
         for (int b = 0; b < SW; b++)
            if (v.we[b]) shadow[v.addr[9:0]][8*b +: 8] = v.wd[8*b +: 8];
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t idle;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Cycle vectors: CPU read, VGA stream, starvation guard,
      // byte-strobe write, read+write collision.
      vecs.push_back(mk(1, 0, 'h10, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h10, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(idle);
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(0, 0, 0, 0, 0, 1, AW'('h100 + i),
                           1, 0, 1, 0, i > 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(idle);
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(1, 0, 'h40, 0, 0, 1, AW'('h200 + k),
                           1, 0, 1, 0, k > 0));
      vecs.push_back(mk(1, 0, 'h40, 0, 0, 1, 'h204, 1, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 'h40, 0, 0, 1, 'h204, 1, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h205, 1, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(idle);
      vecs.push_back(mk(0, 1, 'h20, 'h12345678, 4'b0011, 0, 0,
                        1, 4'b0011, 0, 0, 0));
      vecs.push_back(mk(0, 1, 'h20, 'h12345678, 4'b0011, 0, 0,
                        0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 'h20, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h20, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(idle);
      vecs.push_back(mk(1, 1, 'h30, 'hCAFEF00D, 4'hF, 0, 0,
                        1, 4'hF, 0, 0, 0));
      vecs.push_back(mk(1, 1, 'h30, 'hCAFEF00D, 4'hF, 0, 0,
                        0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 'h30, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h30, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(idle);

      for (int i = 0; i < 1024; i++)
         shadow[i] = 32'h5A000000 + i * 32'h00010003;
      shadow['h10] = 32'hDEADBEEF;
      shadow['h20] = 32'hAAAAAAAA;

      // Reset with both requesters active: nothing may be granted.
      rst  = 1'b1;
      load = 1'b1;
      drive(mk(1, 0, 'h10, 0, 0, 1, 'h100, 0, 0, 0, 0, 0));
      @(negedge clk);
      @(negedge clk);
      load = 1'b0;
      #1;
      chk("rst mem_en", DW'(bus.mem_en), 32'd0);
      chk("rst vga_gnt", DW'(bus.vga_gnt), 32'd0);
      chk("rst cpu_ack", DW'(bus.cpu_ack), 32'd0);
      chk("rst vga_vld", DW'(bus.vga_rd_valid), 32'd0);
      drive(idle);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i], i);

      // Check the strobed write merged into the prior word.
      chk("merge 0x20", shadow['h20], 32'hAAAA5678);

      // Reset lands while a granted CPU read is awaiting its ack.
      @(negedge clk);
      drive(mk(1, 0, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      chk("r5 grant", DW'(bus.mem_en), 32'd1);
      rst = 1'b1;
      #1;
      chk("r5 en_in_rst", DW'(bus.mem_en), 32'd0);
      @(negedge clk);
      bus.vga_req  = 1'b1;
      bus.vga_addr = 'h300;
      #1;
      chk("r5 ack_dropped", DW'(bus.cpu_ack), 32'd0);
      chk("r5 vld", DW'(bus.vga_rd_valid), 32'd0);
      chk("r5 gnt", DW'(bus.vga_gnt), 32'd0);
      chk("r5 wait_cnt", DW'(dut.wait_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.vga_req = 1'b0;
      #1;
      chk("r5 reissue en", DW'(bus.mem_en), 32'd1);
      chk("r5 reissue we", DW'(bus.mem_we), 32'd0);
      chk("r5 reissue addr", DW'(bus.mem_addr), 32'h10);
      @(negedge clk);
      #1;
      chk("r5 ack", DW'(bus.cpu_ack), 32'd1);
      chk("r5 data", bus.cpu_rd_data, 32'hDEADBEEF);
      chk("r5 no_reissue", DW'(bus.mem_en), 32'd0);
      @(negedge clk);
      drive(idle);
      #1;
      chk("r5 ack_pulse", DW'(bus.cpu_ack), 32'd0);

      chk("cpu_q empty", DW'(cpu_q.size()), 32'd0);
      chk("vga_q empty", DW'(vga_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
